// File: rtl/result_formatter_seq_if.sv
// ALU-side handshake and display/memory data bundle for result_formatter_seq.
// The ALU (or a testbench) uses the master modport and the formatter uses the slave modport.
interface result_formatter_seq_if #(
   parameter int BIN_W  = 21,
   parameter int DIGITS = 8
);
   logic                start;
   logic                remain;
   logic [BIN_W-1:0]    alu_result;
   logic [BIN_W-1:0]    alu_remainder;
   logic                busy;
   logic                done;
   logic                overflow;
   logic [4*DIGITS-1:0] formatted;
   logic [4*DIGITS-1:0] mem_word;

   modport master (
      output start,
      output remain,
      output alu_result,
      output alu_remainder,
      input  busy,
      input  done,
      input  overflow,
      input  formatted,
      input  mem_word
   );

   modport slave (
      input  start,
      input  remain,
      input  alu_result,
      input  alu_remainder,
      output busy,
      output done,
      output overflow,
      output formatted,
      output mem_word
   );
endinterface

// File: rtl/result_formatter_seq.sv
// Sequential result formatter: double-dabble BCD conversion, then one display nibble packed per cycle.
// Optional feature macro RESULTFMT_MEMWORD_EN builds the truncated mem_word path; otherwise mem_word is all blanks.
module result_formatter_seq #(
   parameter int BIN_W      = 21,
   parameter int BCD_DIGITS = 7,
   parameter int DIGITS     = 8,
   parameter int MEM_DIGITS = 3
) (
   input logic                   clock,
   input logic                   reset_n,
   result_formatter_seq_if.slave bus
);
   localparam int CW = $clog2(BIN_W + 1);
   localparam int PW = $clog2(DIGITS + 2 * BCD_DIGITS + MEM_DIGITS + 3) + 1;
   localparam int BW = 4 * BCD_DIGITS;
   localparam int OW = 4 * DIGITS;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CONV_RES = 3'd1,
      S_CONV_REM = 3'd2,
      S_PACK     = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [CW-1:0]    cnt_r;
   logic [PW-1:0]    pos_r;
   logic [BIN_W-1:0] sh_r;
   logic [BIN_W-1:0] rem_val_r;
   logic             remain_r;
   logic             neg_r;
   logic [BW-1:0]    res_bcd_r;
   logic [BW-1:0]    rem_bcd_r;
   logic [OW-1:0]    fmt_sh_r;
   logic             ovf_sh_r;
   logic [OW-1:0]    fmt_r;
   logic             ovf_r;
   logic             done_r;
   logic             busy_r;

   logic             start_acc_s;
   logic             cnt_last_s;
   logic             pos_last_s;
   logic [BIN_W-1:0] mag_s;
   logic [PW-1:0]    lres_s;
   logic [PW-1:0]    lrem_s;
   logic [PW-1:0]    off_s;
   logic [PW-1:0]    req_s;
   logic             ovf_s;
   logic [3:0]       field_s;

   // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
   function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] bcd, input logic bit_in);
      logic [BW-1:0] adj;
      adj = bcd;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
         else                       adj[4*i +: 4] = adj[4*i +: 4];
      end
      return {adj[BW-2:0], bit_in};
   endfunction

   function automatic logic [PW-1:0] bcd_len(input logic [BW-1:0] bcd);
      logic [PW-1:0] len;
      len = PW'(1);
      for (int i = 1; i < BCD_DIGITS; i++) begin
         if (bcd[4*i +: 4] != 4'h0) len = PW'(i + 1);
         else                       len = len;
      end
      return len;
   endfunction

   function automatic logic [3:0] bcd_digit(input logic [BW-1:0] bcd, input logic [PW-1:0] idx);
      logic [3:0] d;
      d = 4'h0;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (idx == PW'(i)) d = bcd[4*i +: 4];
         else               d = d;
      end
      return d;
   endfunction

   assign start_acc_s = (state_r == S_IDLE) && bus.start;
   assign cnt_last_s  = (cnt_r == CW'(BIN_W - 1));
   assign pos_last_s  = (pos_r == PW'(DIGITS - 1));
   // Two's-complement negation also gives the correct unsigned magnitude 2^(BIN_W-1) for the most negative input.
   assign mag_s       = bus.alu_result[BIN_W-1] ? (~bus.alu_result + BIN_W'(1)) : bus.alu_result;

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_r <= S_IDLE;
      else          state_r <= state_s;
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (bus.start) state_s = S_CONV_RES;
            else           state_s = S_IDLE;
         end
         S_CONV_RES: begin
            if (cnt_last_s) state_s = remain_r ? S_CONV_REM : S_PACK;
            else            state_s = S_CONV_RES;
         end
         S_CONV_REM: begin
            if (cnt_last_s) state_s = S_PACK;
            else            state_s = S_CONV_REM;
         end
         S_PACK: begin
            if (pos_last_s) state_s = S_DONE;
            else            state_s = S_PACK;
         end
         S_DONE:  state_s = S_IDLE;
         default: state_s = S_IDLE;
      endcase
   end

   // Operand capture and the shared shift-add-3 engine.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sh_r      <= '0;
         rem_val_r <= '0;
         remain_r  <= 1'b0;
         neg_r     <= 1'b0;
         cnt_r     <= '0;
         res_bcd_r <= '0;
         rem_bcd_r <= '0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start_acc_s) begin
                  sh_r      <= mag_s;
                  rem_val_r <= bus.alu_remainder;
                  remain_r  <= bus.remain;
                  neg_r     <= bus.alu_result[BIN_W-1];
                  cnt_r     <= '0;
                  res_bcd_r <= '0;
                  rem_bcd_r <= '0;
               end
            end
            S_CONV_RES: begin
               res_bcd_r <= dd_step(res_bcd_r, sh_r[BIN_W-1]);
               if (cnt_last_s) begin
                  cnt_r <= '0;
                  sh_r  <= rem_val_r;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
                  sh_r  <= {sh_r[BIN_W-2:0], 1'b0};
               end
            end
            S_CONV_REM: begin
               rem_bcd_r <= dd_step(rem_bcd_r, sh_r[BIN_W-1]);
               if (cnt_last_s) cnt_r <= '0;
               else            cnt_r <= cnt_r + CW'(1);
               sh_r <= {sh_r[BIN_W-2:0], 1'b0};
            end
            default: begin
               cnt_r <= '0;
            end
         endcase
      end
   end

   // Digit lengths and the nibble that belongs at the current pack position.
   always_comb begin
      lres_s = bcd_len(res_bcd_r);
      lrem_s = bcd_len(rem_bcd_r);
      off_s  = remain_r ? (lrem_s + PW'(1)) : PW'(0);
      req_s  = off_s + lres_s + (neg_r ? PW'(1) : PW'(0));
      ovf_s  = (req_s > PW'(DIGITS));
      if (ovf_s)                              field_s = 4'hE;
      else if (remain_r && (pos_r < lrem_s))  field_s = bcd_digit(rem_bcd_r, pos_r);
      else if (remain_r && (pos_r == lrem_s)) field_s = 4'hA;
      else if (pos_r < (off_s + lres_s))      field_s = bcd_digit(res_bcd_r, pos_r - off_s);
      else if (neg_r && (pos_r == (off_s + lres_s))) field_s = 4'hE;
      else                                    field_s = 4'hF;
   end

   // Pack position counter and display shadow register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pos_r    <= '0;
         fmt_sh_r <= '1;
         ovf_sh_r <= 1'b0;
      end else if (state_r == S_PACK) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (pos_r == PW'(i)) fmt_sh_r[4*i +: 4] <= field_s;
         end
         ovf_sh_r <= ovf_s;
         pos_r    <= pos_r + PW'(1);
      end else begin
         pos_r <= '0;
      end
   end

   // Visible outputs: updated only in DONE so an aborted operation never leaks partial data.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fmt_r  <= '1;
         ovf_r  <= 1'b0;
         done_r <= 1'b0;
         busy_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            S_IDLE: busy_r <= bus.start;
            S_DONE: begin
               fmt_r  <= fmt_sh_r;
               ovf_r  <= ovf_sh_r;
               done_r <= 1'b1;
               busy_r <= 1'b0;
            end
            default: busy_r <= busy_r;
         endcase
      end
   end

   assign bus.formatted = fmt_r;
   assign bus.overflow  = ovf_r;
   assign bus.done      = done_r;
   assign bus.busy      = busy_r;

`ifdef RESULTFMT_MEMWORD_EN
   logic [PW-1:0] mem_len_s;
   logic [3:0]    mem_field_s;
   logic [OW-1:0] mem_sh_r;
   logic [OW-1:0] mem_r;

   // Memory word keeps only the low result magnitude digits; the sign is never stored.
   always_comb begin
      mem_len_s = (lres_s < PW'(MEM_DIGITS)) ? lres_s : PW'(MEM_DIGITS);
      if (pos_r < mem_len_s) mem_field_s = bcd_digit(res_bcd_r, pos_r);
      else                   mem_field_s = 4'hF;
   end

   // Memory shadow packing and output update.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_sh_r <= '1;
         mem_r    <= '1;
      end else if (state_r == S_PACK) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (pos_r == PW'(i)) mem_sh_r[4*i +: 4] <= mem_field_s;
         end
      end else if (state_r == S_DONE) begin
         mem_r <= mem_sh_r;
      end else begin
         mem_r <= mem_r;
      end
   end

   assign bus.mem_word = mem_r;
`else
   assign bus.mem_word = {DIGITS{4'hF}};
`endif
endmodule

// File: tb/tb_result_formatter_seq.sv
// Directed self-checking bench for result_formatter_seq: decimal reference model, per-cycle compare and literal pins.
module tb_result_formatter_seq;
   localparam int BIN_W  = 21;
   localparam int DIGITS = 8;

   logic clock = 1'b0;
   logic reset_n;

   result_formatter_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

   result_formatter_seq #(
      .BIN_W(BIN_W), .BCD_DIGITS(7), .DIGITS(DIGITS), .MEM_DIGITS(3)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus(bus)
   );

   always #5 clock = ~clock;

   int          n_tests   = 0;
   int          n_fail    = 0;
   int          cyc       = 0;
   int          start_cyc = 0;
   int          done_cyc  = -1;
   bit          op_active = 1'b0;
   logic [31:0] cur_fmt   = '1;
   logic [31:0] cur_mem   = '1;
   bit          cur_ovf   = 1'b0;
   logic [31:0] pend_fmt  = '1;
   logic [31:0] pend_mem  = '1;
   bit          pend_ovf  = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
      end
   endtask

   // Decimal reference: lists the display symbols low position first, then lays them out.
   function automatic void model(input logic [20:0] r, input logic [20:0] rm, input bit rmn,
                                 output logic [31:0] f, output logic [31:0] m, output bit o);
      logic [3:0]  q[$];
      int unsigned v;
      int unsigned mag;
      bit          neg;
      neg = r[20];
      mag = neg ? (32'd2097152 - 32'(r)) : 32'(r);
      if (rmn) begin
         v = 32'(rm);
         do begin q.push_back(4'(v % 10)); v = v / 10; end while (v != 0);
         q.push_back(4'hA);
      end
      v = mag;
      do begin q.push_back(4'(v % 10)); v = v / 10; end while (v != 0);
      if (neg) q.push_back(4'hE);
      f = '1;
      o = (q.size() > DIGITS);
      if (o) f = {DIGITS{4'hE}};
      else for (int i = 0; i < q.size(); i++) f[4*i +: 4] = q[i];
      m = '1;
`ifdef RESULTFMT_MEMWORD_EN
      v = mag;
      for (int i = 0; i < 3; i++) begin
         if (i == 0 || v != 0) m[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
`endif
   endfunction

   // Per-cycle compare against the model, sampled 1 time unit after each rising edge.
   always @(posedge clock) begin
      bit exp_done;
      cyc = cyc + 1;
      #1;
      exp_done = op_active && (cyc == done_cyc);
      if (exp_done) begin
         cur_fmt   = pend_fmt;
         cur_mem   = pend_mem;
         cur_ovf   = pend_ovf;
         op_active = 1'b0;
      end
      chk("done", 32'(bus.done), 32'(exp_done));
      chk("formatted", bus.formatted, cur_fmt);
      chk("mem_word", bus.mem_word, cur_mem);
      chk("overflow", 32'(bus.overflow), 32'(cur_ovf));
      if (op_active && cyc > start_cyc) chk("busy_during_op", 32'(bus.busy), 32'd1);
      else if (!op_active && !exp_done) chk("busy_idle", 32'(bus.busy), 32'd0);
   end

   task automatic launch(input logic [20:0] r, input logic [20:0] rm, input bit rmn);
      model(r, rm, rmn, pend_fmt, pend_mem, pend_ovf);
      start_cyc = cyc;
      done_cyc  = cyc + 1 + 21 + (rmn ? 21 : 0) + 8 + 1;
      op_active = 1'b1;
      bus.start         = 1'b1;
      bus.alu_result    = r;
      bus.alu_remainder = rm;
      bus.remain        = rmn;
      @(negedge clock);
      bus.start         = 1'b0;
      bus.alu_result    = 21'($urandom);
      bus.alu_remainder = 21'($urandom);
      bus.remain        = 1'($urandom);
   endtask

   task automatic wait_done(input logic [31:0] lit_f, input logic [31:0] lit_m, input bit lit_o);
      logic [31:0] exp_m;
      for (int i = 0; i < 150 && op_active; i++) @(negedge clock);
      if (op_active) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_timeout at cycle %0d: got no done, expected done at cycle %0d", cyc, done_cyc);
         op_active = 1'b0;
      end
`ifdef RESULTFMT_MEMWORD_EN
      exp_m = lit_m;
`else
      exp_m = '1;
`endif
      chk("lit_formatted", bus.formatted, lit_f);
      chk("lit_mem_word", bus.mem_word, exp_m);
      chk("lit_overflow", 32'(bus.overflow), 32'(lit_o));
   endtask

   task automatic run_op(input logic [20:0] r, input logic [20:0] rm, input bit rmn,
                         input logic [31:0] lit_f, input logic [31:0] lit_m, input bit lit_o);
      launch(r, rm, rmn);
      wait_done(lit_f, lit_m, lit_o);
   endtask

   initial begin
      reset_n           = 1'b0;
      bus.start         = 1'b0;
      bus.remain        = 1'b0;
      bus.alu_result    = '0;
      bus.alu_remainder = '0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      run_op(21'd1234,     21'd0,    1'b0, 32'hFFFF1234, 32'hFFFFF234, 1'b0);
      run_op(21'h1FFFC8,   21'd7,    1'b1, 32'hFFFE56A7, 32'hFFFFFF56, 1'b0);
      run_op(21'd0,        21'd0,    1'b0, 32'hFFFFFFF0, 32'hFFFFFFF0, 1'b0);
      run_op(21'd1048575,  21'd12,   1'b1, 32'hEEEEEEEE, 32'hFFFFF575, 1'b1);
      run_op(21'h100000,   21'd0,    1'b0, 32'hE1048576, 32'hFFFFF576, 1'b0);
      run_op(21'h1FFF9D,   21'd9999, 1'b1, 32'hE99A9999, 32'hFFFFFF99, 1'b0);
      run_op(21'h1FFC19,   21'd9999, 1'b1, 32'hEEEEEEEE, 32'hFFFFF999, 1'b1);

      // A second start mid-operation must be ignored.
      launch(21'd42, 21'd3, 1'b1);
      repeat (9) @(negedge clock);
      bus.start      = 1'b1;
      bus.alu_result = 21'd777;
      bus.remain     = 1'b0;
      @(negedge clock);
      bus.start = 1'b0;
      wait_done(32'hFFFF42A3, 32'hFFFFFF42, 1'b0);

      // Reset while converting the remainder aborts with no done and no partial update.
      repeat (2) @(negedge clock);
      launch(21'd5, 21'd6, 1'b1);
      repeat (26) @(negedge clock);
      reset_n   = 1'b0;
      op_active = 1'b0;
      done_cyc  = -1;
      cur_fmt   = '1;
      cur_mem   = '1;
      cur_ovf   = 1'b0;
      #1;
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_formatted", bus.formatted, 32'hFFFFFFFF);
      chk("reset_done", 32'(bus.done), 32'd0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (60) @(negedge clock);
      run_op(21'd7, 21'd0, 1'b0, 32'hFFFFFFF7, 32'hFFFFFFF7, 1'b0);

      repeat (5) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of run, expected completion before 200000");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/result_formatter_seq.md
# result_formatter_seq

Sequential, parametrised successor to the calculator's combinational result formatter. It captures a signed ALU result and an optional unsigned remainder on a start strobe. It converts both to BCD with an iterative shift-add-3 engine, then packs display digits one per cycle into a nibble-coded word for the seven-segment driver. It also produces a truncated result word for the memory store, and sits between the ALU and the display/memory blocks.

## Interface
Parameters:
- BIN_W, 21: width of ALU result and remainder.
- BCD_DIGITS, 7: BCD digits held per conversion; must cover 2^(BIN_W-1).
- DIGITS, 8: display digit positions; output width 4*DIGITS.
- MEM_DIGITS, 3: result digits kept in mem_word.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  capture request; honoured only in IDLE.
- remain  in  1  display remainder field when 1.
- alu_result  in  BIN_W  two's-complement result.
- alu_remainder  in  BIN_W  unsigned remainder.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse when outputs update.
- overflow  out  1  field did not fit; held until next done.
- formatted  out  4*DIGITS  display nibbles, digit 0 at [3:0].
- mem_word  out  4*DIGITS  memory-format nibbles.

## Operation
- Nibble codes: 0-9 digits, 4'hA 'r', 4'hE '-', 4'hF blank.
- FSM states: IDLE, CONV_RES, CONV_REM, PACK, DONE.
- IDLE: on start=1, register alu_result, alu_remainder and remain, then go to CONV_RES. The sign is alu_result[BIN_W-1]; magnitude is the absolute value. The most negative input yields magnitude 2^(BIN_W-1), converted correctly.
- CONV_RES: BIN_W cycles of double-dabble on the magnitude, then go to CONV_REM if remain=1, otherwise PACK.
- CONV_REM: BIN_W cycles on the remainder, then PACK.
- Digit length is the position of the highest nonzero BCD digit plus 1; a value of 0 has length 1 ("0").
- Field order from digit 0 upward:
  - when remain: the remainder digits, then 'r';
  - then the result digits;
  - then '-' if negative;
  - blanks in all remaining positions.
- Required positions = Lres + neg + (remain ? Lrem+1 : 0). If this exceeds DIGITS, overflow=1 and formatted is all 4'hE.
- PACK: DIGITS cycles, one digit position written per cycle into a shadow register, low position first.
- mem_word: the low min(Lres, MEM_DIGITS) result magnitude digits at low positions, blanks elsewhere. The sign is never stored.
- DONE: formatted, mem_word and overflow are updated from the shadow registers, done=1 for one cycle, then return to IDLE.
- start while busy is ignored; there is no queueing.
- Outputs hold their last values between operations.

## Timing
- Reset values: formatted all 4'hF, mem_word all 4'hF, busy=0, done=0, overflow=0, state IDLE.
- Start accepted at edge E0. done is high in the cycle following edge E0 + BIN_W + (remain ? BIN_W : 0) + DIGITS + 1.
- With defaults, start-to-done latency is 51 cycles with remainder and 30 without.
- Back-to-back operation: start may be asserted in the cycle done is high. The FSM is in IDLE then, so a new capture occurs at the next edge.
- reset_n low mid-operation immediately forces the reset values and aborts the operation; there is no partial output update.
- Inputs need only be valid in the start cycle.

## Configuration
- RESULTFMT_MEMWORD_EN defined: mem_word logic is built as described.
- Not defined: mem_word is tied to all 4'hF, and its shadow register and packing logic are omitted. formatted, overflow, busy and done behave identically.

## Test plan
- result=1234, remain=0 -> formatted=32'hFFFF1234, mem_word=32'hFFFFF234, overflow=0, done 30 cycles after start.
- result=-56 (21'h1FFFC8), remain=1, remainder=7 -> formatted=32'hFFFE56A7, mem_word=32'hFFFFFF56, done 51 cycles after start.
- result=0, remain=0 -> formatted=32'hFFFFFFF0, mem_word=32'hFFFFFFF0.
- result=1048575, remain=1, remainder=12 -> overflow=1, formatted=32'hEEEEEEEE.
- Pulse start again at cycle 10 of an operation -> ignored; the single done carries the first operand's result.
- reset_n low during CONV_REM -> busy=0 and formatted=32'hFFFFFFFF immediately, no done pulse. A fresh start after release completes normally.
